// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller for HEX digits, LEDR, KEY and SW.
// Keys are synchronised, debounced and edge-captured (W1C) with a level interrupt.
module mmio_io_ctrl #(
  parameter int unsigned      DBITS      = 32,
  parameter int unsigned      NKEYS      = 4,
  parameter int unsigned      NSW        = 10,
  parameter int unsigned      NLEDR      = 10,
  parameter int unsigned      NHEX       = 6,
  parameter logic [15:0]      DEB_CYCLES = 16'd50000,
  parameter logic [DBITS-1:0] ADDRHEX    = 32'hFFFFF000,
  parameter logic [DBITS-1:0] ADDRLEDR   = 32'hFFFFF020,
  parameter logic [DBITS-1:0] ADDRKEY    = 32'hFFFFF080,
  parameter logic [DBITS-1:0] ADDRKEDGE  = 32'hFFFFF084,
  parameter logic [DBITS-1:0] ADDRKIE    = 32'hFFFFF088,
  parameter logic [DBITS-1:0] ADDRSW     = 32'hFFFFF090
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DBITS-1:0]  addr,
  input  logic [DBITS-1:0]  wdata,
  input  logic              we,
  input  logic              re,
  output logic              hit,
  output logic [DBITS-1:0]  rdata,
  output logic              rvalid,
  input  logic [NKEYS-1:0]  key_n,
  input  logic [NSW-1:0]    sw,
  output logic [NLEDR-1:0]  ledr,
  output logic [4*NHEX-1:0] hex_digits,
  output logic              irq
);

  localparam int unsigned HEXW = 4 * NHEX;
  // Counter only has to reach DEB_CYCLES-1; a 1-cycle debounce still needs one bit.
  localparam int unsigned CW = (DEB_CYCLES > 16'd1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 16'd1);

  logic             sel_hex_s, sel_ledr_s, sel_key_s, sel_kedge_s, sel_kie_s, sel_sw_s;
  logic [NKEYS-1:0] key_sync1_q, key_sync2_q;
  logic [NSW-1:0]   sw_sync1_q, sw_sync2_q;
  logic [NKEYS-1:0] key_samp_s;
  logic [NKEYS-1:0] key_stable_q, key_stable_d;
  logic [CW-1:0]    deb_cnt_q [NKEYS];
  logic [CW-1:0]    deb_cnt_d [NKEYS];
  logic [NKEYS-1:0] key_rise_s, edge_clr_s;
  logic [NKEYS-1:0] edge_q, edge_d;
  logic [NKEYS-1:0] ie_q, ie_d;
  logic [HEXW-1:0]  hex_q, hex_d;
  logic [NLEDR-1:0] ledr_q, ledr_d;
  logic [DBITS-1:0] rd_mux_s;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic             rvalid_q;
  logic             irq_q;
  logic             unused_wdata_s;

  assign sel_hex_s   = (addr == ADDRHEX);
  assign sel_ledr_s  = (addr == ADDRLEDR);
  assign sel_key_s   = (addr == ADDRKEY);
  assign sel_kedge_s = (addr == ADDRKEDGE);
  assign sel_kie_s   = (addr == ADDRKIE);
  assign sel_sw_s    = (addr == ADDRSW);
  assign hit = sel_hex_s | sel_ledr_s | sel_key_s | sel_kedge_s | sel_kie_s | sel_sw_s;

  // Buttons are active-low on the board; internally 1 means pressed.
  assign key_samp_s = ~key_sync2_q;
  assign unused_wdata_s = ^wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_sync1_q <= '1;
      key_sync2_q <= '1;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
    end else begin
      key_sync1_q <= key_n;
      key_sync2_q <= key_sync1_q;
      sw_sync1_q  <= sw;
      sw_sync2_q  <= sw_sync1_q;
    end
  end

  always_comb begin
    key_stable_d = key_stable_q;
    for (int i = 0; i < NKEYS; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (key_samp_s[i] == key_stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == CNT_MAX) begin
        key_stable_d[i] = key_samp_s[i];
        deb_cnt_d[i]    = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
      end
    end
  end

  // A new press in the same cycle as a W1C clear must survive, so set is applied last.
  always_comb begin
    key_rise_s = key_stable_d & ~key_stable_q;
    if (we && sel_kedge_s) begin
      edge_clr_s = wdata[NKEYS-1:0];
    end else begin
      edge_clr_s = '0;
    end
    edge_d = (edge_q & ~edge_clr_s) | key_rise_s;
  end

  always_comb begin
    hex_d  = hex_q;
    ledr_d = ledr_q;
    ie_d   = ie_q;
    if (we && sel_hex_s) begin
      hex_d = wdata[HEXW-1:0];
    end else begin
      hex_d = hex_q;
    end
    if (we && sel_ledr_s) begin
      ledr_d = wdata[NLEDR-1:0];
    end else begin
      ledr_d = ledr_q;
    end
    if (we && sel_kie_s) begin
      ie_d = wdata[NKEYS-1:0];
    end else begin
      ie_d = ie_q;
    end
  end

  // Read mux samples pre-write register state, so a same-cycle write is not visible.
  always_comb begin
    rd_mux_s = '0;
    if (sel_hex_s) begin
      rd_mux_s[HEXW-1:0] = hex_q;
    end else if (sel_ledr_s) begin
      rd_mux_s[NLEDR-1:0] = ledr_q;
    end else if (sel_key_s) begin
      rd_mux_s[NKEYS-1:0] = key_stable_q;
    end else if (sel_kedge_s) begin
      rd_mux_s[NKEYS-1:0] = edge_q;
    end else if (sel_kie_s) begin
      rd_mux_s[NKEYS-1:0] = ie_q;
    end else if (sel_sw_s) begin
      rd_mux_s[NSW-1:0] = sw_sync2_q;
    end else begin
      rd_mux_s = '0;
    end
    if (re) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_stable_q <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        deb_cnt_q[i] <= '0;
      end
      edge_q   <= '0;
      ie_q     <= '0;
      hex_q    <= '0;
      ledr_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      key_stable_q <= key_stable_d;
      for (int i = 0; i < NKEYS; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
      edge_q   <= edge_d;
      ie_q     <= ie_d;
      hex_q    <= hex_d;
      ledr_q   <= ledr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= re;
      irq_q    <= |(edge_q & ie_q);
    end
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign ledr       = ledr_q;
  assign hex_digits = hex_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Bench for mmio_io_ctrl: directed steps then random bus/key/switch traffic,
// checked every cycle against a queue-based behavioural model.
module tb_mmio_io_ctrl;

  localparam logic [15:0] DEB     = 16'd4;
  localparam logic [31:0] A_HEX   = 32'hFFFFF000;
  localparam logic [31:0] A_LEDR  = 32'hFFFFF020;
  localparam logic [31:0] A_KEY   = 32'hFFFFF080;
  localparam logic [31:0] A_KEDGE = 32'hFFFFF084;
  localparam logic [31:0] A_KIE   = 32'hFFFFF088;
  localparam logic [31:0] A_SW    = 32'hFFFFF090;
  localparam logic [31:0] A_BAD   = 32'hFFFFF0A0;

  logic        clk, reset;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, hit, rvalid, irq;
  logic [3:0]  key_n;
  logic [9:0]  sw, ledr;
  logic [23:0] hex_digits;

  mmio_io_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .hit(hit), .rdata(rdata), .rvalid(rvalid), .key_n(key_n), .sw(sw),
    .ledr(ledr), .hex_digits(hex_digits), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: kq/sq hold the two in-flight synchroniser samples, hist the recent key samples.
  logic [23:0] m_hex;
  logic [9:0]  m_ledr;
  logic [3:0]  m_key, m_edge, m_ie;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_irq;
  logic [3:0]  kq [$];
  logic [9:0]  sq [$];
  logic [3:0]  hist [$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a)
      A_HEX:   return {8'h00, m_hex};
      A_LEDR:  return {22'h0, m_ledr};
      A_KEY:   return {28'h0, m_key};
      A_KEDGE: return {28'h0, m_edge};
      A_KIE:   return {28'h0, m_ie};
      A_SW:    return {22'h0, sq[0]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_hex = 24'h0; m_ledr = 10'h0; m_key = 4'h0; m_edge = 4'h0; m_ie = 4'h0;
    m_rdata = 32'h0; m_rvalid = 1'b0; m_irq = 1'b0;
    kq.delete(); sq.delete(); hist.delete();
    kq.push_back(4'h0); kq.push_back(4'h0);
    sq.push_back(10'h0); sq.push_back(10'h0);
  endtask

  // One clock edge of the model, evaluated from the inputs present before the edge.
  task automatic model_step();
    logic [3:0] s, nk, clr;
    logic       irq_n, all_diff;
    irq_n = |(m_edge & m_ie);
    if (re) m_rdata = m_read(addr);
    m_rvalid = re;
    s = kq.pop_front();
    kq.push_back(~key_n);
    void'(sq.pop_front());
    sq.push_back(sw);
    hist.push_back(s);
    if (hist.size() > int'(DEB)) void'(hist.pop_front());
    nk = m_key;
    if (hist.size() == int'(DEB)) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        foreach (hist[j]) if (hist[j][i] == m_key[i]) all_diff = 1'b0;
        if (all_diff) nk[i] = ~m_key[i];
      end
    end
    clr = (we && addr == A_KEDGE) ? wdata[3:0] : 4'h0;
    m_edge = (m_edge & ~clr) | (nk & ~m_key);
    m_key = nk;
    if (we && addr == A_HEX)  m_hex  = wdata[23:0];
    if (we && addr == A_LEDR) m_ledr = wdata[9:0];
    if (we && addr == A_KIE)  m_ie   = wdata[3:0];
    m_irq = irq_n;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(m_rvalid));
    chk({tag, ".rdata"}, rdata, m_rdata);
    chk({tag, ".ledr"}, 32'(ledr), 32'(m_ledr));
    chk({tag, ".hex"}, 32'(hex_digits), 32'(m_hex));
    chk({tag, ".irq"}, 32'(irq), 32'(m_irq));
  endtask

  task automatic tick();
    logic exp_hit;
    #1;
    exp_hit = (addr == A_HEX) || (addr == A_LEDR) || (addr == A_KEY) ||
              (addr == A_KEDGE) || (addr == A_KIE) || (addr == A_SW);
    chk("hit", 32'(hit), 32'(exp_hit));
    model_step();
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1; re = 1'b0;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a; re = 1'b1; we = 1'b0;
    tick();
    re = 1'b0;
  endtask

  logic [31:0] addrs [7];

  initial begin
    addrs = '{A_HEX, A_LEDR, A_KEY, A_KEDGE, A_KIE, A_SW, A_BAD};
    reset = 1'b1; key_n = 4'hF; sw = 10'h0;
    addr = 32'h0; wdata = 32'h0; we = 1'b0; re = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset = 1'b0;

    // Every register reads zero after reset, one rvalid per read.
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i]);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h1);
    end
    addr = A_BAD;
    tick();
    chk("rvalid_pulse", 32'(rvalid), 32'h0);

    wr(A_HEX, 32'h00ABCDEF);
    wr(A_LEDR, 32'h000003FF);
    chk("hex_val", 32'(hex_digits), 32'h00ABCDEF);
    chk("ledr_val", 32'(ledr), 32'h3FF);
    rd(A_HEX);
    chk("hex_rd", rdata, 32'h00ABCDEF);
    rd(A_LEDR);
    chk("ledr_rd", rdata, 32'h000003FF);
    addr = A_BAD;
    #1;
    chk("bad_hit", 32'(hit), 32'h0);
    wr(A_BAD, 32'hFFFFFFFF);
    chk("bad_hex", 32'(hex_digits), 32'h00ABCDEF);
    chk("bad_ledr", 32'(ledr), 32'h3FF);
    rd(A_BAD);
    chk("bad_rd", rdata, 32'h0);

    // Short press is rejected, a long one is accepted and captured.
    key_n = 4'b1011;
    repeat (3) tick();
    key_n = 4'hF;
    repeat (8) tick();
    rd(A_KEY);
    chk("deb_short", rdata, 32'h0);
    key_n = 4'b1011;
    repeat (6) tick();
    rd(A_KEY);
    chk("deb_long", rdata, 32'h4);
    rd(A_KEDGE);
    chk("edge_set", rdata, 32'h4);

    wr(A_KIE, 32'h4);
    tick();
    chk("irq_on", 32'(irq), 32'h1);
    wr(A_KEDGE, 32'h4);
    tick();
    chk("irq_off", 32'(irq), 32'h0);
    rd(A_KEDGE);
    chk("edge_clr", rdata, 32'h0);
    key_n = 4'hF;
    repeat (8) tick();
    rd(A_KEDGE);
    chk("release_no_edge", rdata, 32'h0);
    // Press accepted on the sixth edge; the W1C lands on that same edge.
    key_n = 4'b1011;
    repeat (5) tick();
    wr(A_KEDGE, 32'h4);
    rd(A_KEDGE);
    chk("w1c_vs_set", rdata, 32'h4);

    sw = 10'h2A5;
    addr = A_SW; re = 1'b1;
    tick();
    chk("sw_lat1", rdata, 32'h0);
    tick();
    chk("sw_lat2", rdata, 32'h0);
    tick();
    chk("sw_lat3", rdata, 32'h2A5);
    re = 1'b0;

    wr(A_LEDR, 32'h0);
    addr = A_LEDR; wdata = 32'h155; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    chk("rw_old", rdata, 32'h0);
    chk("rw_new", 32'(ledr), 32'h155);

    // Reset arrives while a read is pending.
    addr = A_LEDR; re = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_async_ledr", 32'(ledr), 32'h0);
    chk("rst_async_hex", 32'(hex_digits), 32'h0);
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    re = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_no_rvalid", 32'(rvalid), 32'h0);
    end

    for (int n = 0; n < 3000; n++) begin
      addr  = addrs[$urandom_range(0, 6)];
      wdata = $urandom;
      we    = ($urandom_range(0, 3) == 0);
      re    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) key_n[$urandom_range(0, 3)] = ~key_n[$urandom_range(0, 3)];
      if ($urandom_range(0, 19) == 0) sw = 10'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
